// File: rtl/oldest2_issue_queue_if.sv
// Signal bundle between the oldest-2 issue queue, its allocator/scoreboard and the oldest-2 arbiter.
// The queue takes the slave view; whoever drives allocation, wakeup and grants takes the master view.
interface oldest2_issue_queue_if #(
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 32
);
    logic                    flush_i;
    logic [1:0]              alloc_valid_i;
    logic [1:0]              alloc_rdy_bit_i;
    logic [1:0]              alloc_is_ls_i;
    logic [2*DATA_WIDTH-1:0] alloc_data_i;
    logic                    alloc_ready_o;
    logic [2*PTR_WIDTH-1:0]  alloc_index_o;
    logic [DEPTH-1:0]        ready_set_i;
    logic [DEPTH-1:0]        req_o;
    logic [DEPTH-1:0]        req_ls_o;
    logic [PTR_WIDTH-1:0]    head_o;
    logic [1:0]              new_req_o;
    logic [1:0]              new_req_ls_o;
    logic                    first_grant_valid_i;
    logic                    second_grant_valid_i;
    logic [PTR_WIDTH-1:0]    first_grant_index_i;
    logic [PTR_WIDTH-1:0]    second_grant_index_i;
    logic [1:0]              new_grant_i;
    logic [1:0]              issue_valid_o;
    logic [2*DATA_WIDTH-1:0] issue_data_o;

    modport master (
        output flush_i, alloc_valid_i, alloc_rdy_bit_i, alloc_is_ls_i, alloc_data_i, ready_set_i,
               first_grant_valid_i, second_grant_valid_i, first_grant_index_i, second_grant_index_i,
               new_grant_i,
        input  alloc_ready_o, alloc_index_o, req_o, req_ls_o, head_o, new_req_o, new_req_ls_o,
               issue_valid_o, issue_data_o
    );

    modport slave (
        input  flush_i, alloc_valid_i, alloc_rdy_bit_i, alloc_is_ls_i, alloc_data_i, ready_set_i,
               first_grant_valid_i, second_grant_valid_i, first_grant_index_i, second_grant_index_i,
               new_grant_i,
        output alloc_ready_o, alloc_index_o, req_o, req_ls_o, head_o, new_req_o, new_req_ls_o,
               issue_valid_o, issue_data_o
    );
endinterface

// File: rtl/oldest2_issue_queue.sv
// Age-ordered 8-entry issue buffer feeding an oldest-2 arbiter: in-order allocation at tail,
// out-of-order retirement by grant, head skipping holes, two registered issue slots.
module oldest2_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rstn,
    oldest2_issue_queue_if.slave q
);
    typedef logic [PTR_WIDTH:0] ptr_t;

    logic [DEPTH-1:0]        valid_q, ready_q, is_ls_q;
    logic [DEPTH-1:0]        valid_d, ready_d, is_ls_d, freed;
    logic [DATA_WIDTH-1:0]   data_q [DEPTH];
    ptr_t                    head_q, tail_q, head_d, tail_d, span, span_d, p;
    logic [PTR_WIDTH-1:0]    idx0, idx1;
    logic                    alloc_ready, accept, bypass0, wr0, wr1, found;
    logic [3:0]              cand_v;
    logic [DATA_WIDTH-1:0]   cand_d [4];
    logic [1:0]              issue_valid_p0, issue_valid_p1;
    logic [2*DATA_WIDTH-1:0] issue_data_p0, issue_data_p1;
    int                      n;

    // Wrap bit in the pointers makes span == DEPTH (full) distinct from span == 0 (empty).
    assign span        = tail_q - head_q;
    assign alloc_ready = (span <= ptr_t'(DEPTH - 2));
    assign accept      = alloc_ready & ~q.flush_i;
    assign bypass0     = q.alloc_valid_i[0] & q.new_grant_i[0];
    assign wr0         = accept & q.alloc_valid_i[0] & ~q.new_grant_i[0];
    assign wr1         = accept & q.alloc_valid_i[1] & ~q.new_grant_i[1];
    assign idx0        = tail_q[PTR_WIDTH-1:0];
    assign idx1        = bypass0 ? idx0 : idx0 + PTR_WIDTH'(1);
    assign tail_d      = tail_q + ptr_t'(wr0) + ptr_t'(wr1);
    assign span_d      = tail_d - head_q;

    assign q.alloc_ready_o = alloc_ready;
    assign q.alloc_index_o = {idx1, idx0};
    assign q.new_req_o     = q.alloc_valid_i & q.alloc_rdy_bit_i & {2{alloc_ready}};
    assign q.new_req_ls_o  = q.alloc_valid_i & q.alloc_is_ls_i & {2{alloc_ready}};
    assign q.req_o         = valid_q & ready_q;
    assign q.req_ls_o      = valid_q & is_ls_q;
    assign q.head_o        = head_q[PTR_WIDTH-1:0];
    assign q.issue_valid_o = issue_valid_p1;
    assign q.issue_data_o  = issue_data_p1;

    always_comb begin
        freed = '0;
        if (q.first_grant_valid_i)  freed[q.first_grant_index_i]  = 1'b1;
        if (q.second_grant_valid_i) freed[q.second_grant_index_i] = 1'b1;
        valid_d = valid_q & ~freed;
        // Masking with post-free valid drops wakeups to empty or just-granted entries.
        ready_d = (ready_q | q.ready_set_i) & valid_d;
        is_ls_d = is_ls_q;
        if (wr0) begin
            valid_d[idx0] = 1'b1;
            ready_d[idx0] = q.alloc_rdy_bit_i[0];
            is_ls_d[idx0] = q.alloc_is_ls_i[0];
        end
        if (wr1) begin
            valid_d[idx1] = 1'b1;
            ready_d[idx1] = q.alloc_rdy_bit_i[1];
            is_ls_d[idx1] = q.alloc_is_ls_i[1];
        end
    end

    // Search spans up to the new tail so fresh allocations into an emptied queue stay visible.
    always_comb begin
        head_d = tail_d;
        found  = 1'b0;
        p      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            p = head_q + ptr_t'(i);
            if (!found && (ptr_t'(i) < span_d) && valid_d[p[PTR_WIDTH-1:0]]) begin
                head_d = p;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        cand_v    = {q.new_grant_i[1], q.new_grant_i[0], q.second_grant_valid_i, q.first_grant_valid_i};
        cand_d[0] = data_q[q.first_grant_index_i];
        cand_d[1] = data_q[q.second_grant_index_i];
        cand_d[2] = q.alloc_data_i[DATA_WIDTH-1:0];
        cand_d[3] = q.alloc_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
        issue_valid_p0 = '0;
        issue_data_p0  = '0;
        n              = 0;
        for (int k = 0; k < 4; k++) begin
            if (cand_v[k]) begin
                if (n == 0) begin
                    issue_valid_p0[0]                = 1'b1;
                    issue_data_p0[DATA_WIDTH-1:0]    = cand_d[k];
                end else if (n == 1) begin
                    issue_valid_p0[1]                = 1'b1;
                    issue_data_p0[2*DATA_WIDTH-1:DATA_WIDTH] = cand_d[k];
                end
                n = n + 1;
            end
        end
    end

    // ---- stage p0 -> p1: queue state and issue slots ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q        <= '0;
            ready_q        <= '0;
            is_ls_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            issue_valid_p1 <= '0;
            issue_data_p1  <= '0;
        end else if (q.flush_i) begin
            valid_q        <= '0;
            ready_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            issue_valid_p1 <= '0;
        end else begin
            valid_q        <= valid_d;
            ready_q        <= ready_d;
            is_ls_q        <= is_ls_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            issue_valid_p1 <= issue_valid_p0;
            issue_data_p1  <= issue_data_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0) data_q[idx0] <= q.alloc_data_i[DATA_WIDTH-1:0];
        if (wr1) data_q[idx1] <= q.alloc_data_i[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    // The arbiter never returns more than two grants per cycle.
    grant_count_a: assert property (@(posedge clk) disable iff (!rstn) $countones(cand_v) <= 2);
endmodule

// File: tb/tb_oldest2_issue_queue.sv
// Bench for oldest2_issue_queue: the bench plays arbiter/allocator against a slot-array model
// with unbounded head/tail counters, plus directed scenarios with literal expectations.
module tb_oldest2_issue_queue;
    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam int DW    = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    oldest2_issue_queue_if #(.DEPTH(DEPTH), .PTR_WIDTH(PW), .DATA_WIDTH(DW)) bus ();
    oldest2_issue_queue #(.DEPTH(DEPTH), .PTR_WIDTH(PW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rstn(rstn),
        .q   (bus)
    );

    bit          m_valid [DEPTH];
    bit          m_ready [DEPTH];
    bit          m_ls    [DEPTH];
    logic [DW-1:0] m_data [DEPTH];
    int          m_head, m_tail;
    logic [1:0]  e_iv;
    logic [DW-1:0] e_id [2];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_alloc_ready();
        return (DEPTH - (m_tail - m_head)) >= 2;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < DEPTH; e++) begin
            m_valid[e] = 0; m_ready[e] = 0; m_ls[e] = 0; m_data[e] = '0;
        end
        m_head = 0; m_tail = 0; e_iv = 2'b00; e_id[0] = '0; e_id[1] = '0;
    endtask

    task automatic drive_idle();
        bus.flush_i = 1'b0; bus.alloc_valid_i = '0; bus.alloc_rdy_bit_i = '0; bus.alloc_is_ls_i = '0;
        bus.alloc_data_i = '0; bus.ready_set_i = '0; bus.first_grant_valid_i = 1'b0;
        bus.second_grant_valid_i = 1'b0; bus.first_grant_index_i = '0; bus.second_grant_index_i = '0;
        bus.new_grant_i = '0;
    endtask

    task automatic set_alloc(input logic [1:0] av, input logic [1:0] rdy, input logic [1:0] ls,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.alloc_valid_i = av; bus.alloc_rdy_bit_i = rdy; bus.alloc_is_ls_i = ls;
        bus.alloc_data_i = {d1, d0};
    endtask

    task automatic grant_q(input bit fv, input int fi, input bit sv, input int si);
        bus.first_grant_valid_i = fv;  bus.first_grant_index_i  = PW'(fi);
        bus.second_grant_valid_i = sv; bus.second_grant_index_i = PW'(si);
    endtask

    task automatic compare_outputs();
        logic [DEPTH-1:0] er, el;
        logic [1:0] enr, enl;
        bit ar;
        int i1;
        ar = m_alloc_ready();
        for (int e = 0; e < DEPTH; e++) begin
            er[e] = m_valid[e] && m_ready[e];
            el[e] = m_valid[e] && m_ls[e];
        end
        for (int s = 0; s < 2; s++) begin
            enr[s] = bus.alloc_valid_i[s] && bus.alloc_rdy_bit_i[s] && ar;
            enl[s] = bus.alloc_valid_i[s] && bus.alloc_is_ls_i[s] && ar;
        end
        i1 = m_tail + ((bus.alloc_valid_i[0] && bus.new_grant_i[0]) ? 0 : 1);
        chk("req",         64'(bus.req_o),         64'(er));
        chk("req_ls",      64'(bus.req_ls_o),      64'(el));
        chk("head",        64'(bus.head_o),        64'(m_head % DEPTH));
        chk("alloc_ready", 64'(bus.alloc_ready_o), 64'(ar));
        chk("alloc_index", 64'(bus.alloc_index_o), 64'((i1 % DEPTH) * DEPTH + (m_tail % DEPTH)));
        chk("new_req",     64'(bus.new_req_o),     64'(enr));
        chk("new_req_ls",  64'(bus.new_req_ls_o),  64'(enl));
        chk("issue_valid", 64'(bus.issue_valid_o), 64'(e_iv));
        if (e_iv[0]) chk("issue_data0", 64'(bus.issue_data_o[DW-1:0]),    64'(e_id[0]));
        if (e_iv[1]) chk("issue_data1", 64'(bus.issue_data_o[2*DW-1:DW]), 64'(e_id[1]));
    endtask

    task automatic model_update();
        bit v [4];
        logic [DW-1:0] d [4];
        bit ar;
        int n, idx;
        if (bus.flush_i) begin
            for (int e = 0; e < DEPTH; e++) m_valid[e] = 0;
            m_head = 0; m_tail = 0; e_iv = 2'b00;
            return;
        end
        ar = m_alloc_ready();
        v[0] = bus.first_grant_valid_i;  d[0] = m_data[bus.first_grant_index_i];
        v[1] = bus.second_grant_valid_i; d[1] = m_data[bus.second_grant_index_i];
        v[2] = bus.new_grant_i[0];       d[2] = bus.alloc_data_i[DW-1:0];
        v[3] = bus.new_grant_i[1];       d[3] = bus.alloc_data_i[2*DW-1:DW];
        n = 0;
        for (int k = 0; k < 4; k++)
            if (v[k]) begin
                if (n < 2) e_id[n] = d[k];
                n++;
            end
        e_iv = (n >= 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
        if (v[0]) m_valid[bus.first_grant_index_i]  = 0;
        if (v[1]) m_valid[bus.second_grant_index_i] = 0;
        for (int e = 0; e < DEPTH; e++)
            if (m_valid[e] && bus.ready_set_i[e]) m_ready[e] = 1;
        if (ar)
            for (int s = 0; s < 2; s++)
                if (bus.alloc_valid_i[s] && !bus.new_grant_i[s]) begin
                    idx = m_tail % DEPTH;
                    m_valid[idx] = 1; m_ready[idx] = bus.alloc_rdy_bit_i[s];
                    m_ls[idx] = bus.alloc_is_ls_i[s];
                    m_data[idx] = (s == 0) ? bus.alloc_data_i[DW-1:0] : bus.alloc_data_i[2*DW-1:DW];
                    m_tail++;
                end
        while (m_head < m_tail && !m_valid[m_head % DEPTH]) m_head++;
    endtask

    task automatic step();
        #1;
        compare_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic rand_cycle();
        int pool[$];
        int pick, ent, g;
        bit ar;
        logic [1:0] av;
        drive_idle();
        ar = m_alloc_ready();
        bus.flush_i     = ($urandom_range(0, 59) == 0);
        bus.ready_set_i = DEPTH'($urandom & $urandom);
        case ($urandom_range(0, 3))
            0:       av = 2'b00;
            1:       av = 2'b01;
            default: av = 2'b11;
        endcase
        set_alloc(av, 2'($urandom), 2'($urandom), $urandom, $urandom);
        for (int e = 0; e < DEPTH; e++) if (m_valid[e] && m_ready[e]) pool.push_back(e);
        for (int s = 0; s < 2; s++) if (av[s] && bus.alloc_rdy_bit_i[s] && ar) pool.push_back(100 + s);
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
            if (pool.size() == 0) break;
            pick = $urandom_range(0, pool.size() - 1);
            ent  = pool[pick];
            pool.delete(pick);
            if (ent >= 100) bus.new_grant_i[ent - 100] = 1'b1;
            else if (!bus.first_grant_valid_i) grant_q(1, ent, 0, 0);
            else begin
                bus.second_grant_valid_i = 1'b1; bus.second_grant_index_i = PW'(ent);
            end
        end
        if (bus.first_grant_valid_i && !bus.second_grant_valid_i && $urandom_range(0, 3) == 0)
            grant_q(0, 0, 1, int'(bus.first_grant_index_i));
    endtask

    initial begin
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",         64'(bus.req_o),         64'h0);
        chk("rst_head",        64'(bus.head_o),        64'h0);
        chk("rst_alloc_ready", 64'(bus.alloc_ready_o), 64'h1);
        chk("rst_issue_valid", 64'(bus.issue_valid_o), 64'h0);
        chk("rst_issue_data",  64'(bus.issue_data_o),  64'h0);
        rstn = 1'b1;
        @(negedge clk);

        // fill with 2 ready ops per cycle, no grants
        for (int c = 0; c < 4; c++) begin
            set_alloc(2'b11, 2'b11, 2'b00, 32'h10 + 2 * c, 32'h11 + 2 * c);
            step();
        end
        drive_idle(); #1;
        chk("fill_req",         64'(bus.req_o),         64'hFF);
        chk("fill_alloc_ready", 64'(bus.alloc_ready_o), 64'h0);
        bus.flush_i = 1'b1;
        step();

        // bypass on an empty queue
        drive_idle();
        set_alloc(2'b01, 2'b01, 2'b00, 32'hA5A5_0001, 32'h0);
        bus.new_grant_i = 2'b01;
        step();
        drive_idle(); #1;
        chk("byp_issue_valid", 64'(bus.issue_valid_o),      64'h1);
        chk("byp_issue_data",  64'(bus.issue_data_o[31:0]), 64'hA5A5_0001);
        chk("byp_tail",        64'(bus.alloc_index_o[2:0]), 64'h0);
        chk("byp_req",         64'(bus.req_o),              64'h0);

        // out-of-order grants with head skipping holes
        for (int c = 0; c < 3; c++) begin
            set_alloc(2'b11, 2'b11, 2'b00, 32'h100 + 2 * c, 32'h101 + 2 * c);
            step();
        end
        drive_idle(); grant_q(1, 0, 1, 2); step();
        drive_idle(); #1;
        chk("ooo_issue_valid", 64'(bus.issue_valid_o), 64'h3);
        chk("ooo_issue_data",  64'(bus.issue_data_o),  64'h0000_0102_0000_0100);
        chk("ooo_head1",       64'(bus.head_o),        64'h1);
        grant_q(1, 1, 0, 0); step();
        drive_idle(); #1;
        chk("ooo_head3", 64'(bus.head_o), 64'h3);

        // wrap-around: drain 3..5, refill 6,7,0,1, free 6,7
        grant_q(1, 3, 1, 4); step();
        drive_idle(); grant_q(1, 5, 0, 0); step();
        drive_idle(); set_alloc(2'b11, 2'b11, 2'b00, 32'h206, 32'h207); step();
        drive_idle(); set_alloc(2'b11, 2'b11, 2'b00, 32'h200, 32'h201); step();
        drive_idle(); grant_q(1, 6, 1, 7); step();
        drive_idle(); #1;
        chk("wrap_head",        64'(bus.head_o),        64'h0);
        chk("wrap_alloc_ready", 64'(bus.alloc_ready_o), 64'h1);
        chk("wrap_alloc_index", 64'(bus.alloc_index_o), 64'h1A);

        // full queue of unready ops, targeted wakeup, hole not reused
        bus.flush_i = 1'b1; step();
        for (int c = 0; c < 4; c++) begin
            drive_idle(); set_alloc(2'b11, 2'b00, 2'b10, 32'h300 + 2 * c, 32'h301 + 2 * c);
            step();
        end
        drive_idle(); bus.ready_set_i = 8'h10; step();
        drive_idle(); #1;
        chk("wake_req",         64'(bus.req_o),         64'h10);
        chk("wake_req_ls",      64'(bus.req_ls_o),      64'hAA);
        bus.ready_set_i = 8'h03; grant_q(1, 4, 0, 0); step();
        drive_idle(); #1;
        chk("hole_req",         64'(bus.req_o),         64'h03);
        chk("hole_alloc_ready", 64'(bus.alloc_ready_o), 64'h0);
        chk("hole_issue_data",  64'(bus.issue_data_o[31:0]), 64'h304);
        grant_q(1, 0, 1, 1); step();
        drive_idle(); #1;
        chk("drain_head", 64'(bus.head_o), 64'h2);
        bus.ready_set_i = 8'h20; step();
        drive_idle(); grant_q(1, 5, 0, 0);
        set_alloc(2'b01, 2'b01, 2'b00, 32'hBEEF_0005, 32'h0);
        bus.new_grant_i = 2'b01;
        step();
        drive_idle(); #1;
        chk("mix_issue_valid", 64'(bus.issue_valid_o), 64'h3);
        chk("mix_issue_data",  64'(bus.issue_data_o),  64'hBEEF_0005_0000_0305);

        // flush beats grants and allocation in the same cycle
        bus.ready_set_i = 8'h0C; step();
        drive_idle(); bus.flush_i = 1'b1; grant_q(1, 2, 1, 3);
        set_alloc(2'b11, 2'b11, 2'b11, 32'h400, 32'h401);
        step();
        drive_idle(); #1;
        chk("flush_issue_valid", 64'(bus.issue_valid_o), 64'h0);
        chk("flush_req",         64'(bus.req_o),         64'h0);
        chk("flush_head",        64'(bus.head_o),        64'h0);
        chk("flush_alloc_ready", 64'(bus.alloc_ready_o), 64'h1);

        // asynchronous reset mid-queue
        set_alloc(2'b11, 2'b11, 2'b00, 32'h500, 32'h501); step();
        drive_idle(); set_alloc(2'b11, 2'b11, 2'b00, 32'h502, 32'h503); step();
        drive_idle(); grant_q(1, 0, 0, 0); step();
        drive_idle();
        rstn = 1'b0;
        #1;
        chk("arst_req",         64'(bus.req_o),         64'h0);
        chk("arst_head",        64'(bus.head_o),        64'h0);
        chk("arst_alloc_ready", 64'(bus.alloc_ready_o), 64'h1);
        chk("arst_issue_valid", 64'(bus.issue_valid_o), 64'h0);
        chk("arst_issue_data",  64'(bus.issue_data_o),  64'h0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rand_cycle();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/oldest2_issue_queue.md
# oldest2_issue_queue

Age-ordered 8-entry issue buffer that sits directly upstream of the oldest-2 arbiter. It produces the arbiter's request vectors, load/store mask, head pointer and new-request bypass bits. It consumes the two grants the arbiter returns, frees the granted entries and drives up to two registered issue slots toward execution. Entries are allocated in order at the tail and retire out of order. The head skips holes so that the arbiter's priority point is always the oldest live entry.

## Interface
- DEPTH, 8, entry count (power of two)
- PTR_WIDTH, 3, log2(DEPTH)
- DATA_WIDTH, 32, opaque payload width
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- flush_i  in  1  discard all entries
- alloc_valid_i  in  2  allocation slots; bit1 only with bit0
- alloc_rdy_bit_i  in  2  operands ready at allocation
- alloc_is_ls_i  in  2  slot is a load/store
- alloc_data_i  in  2*DATA_WIDTH  payloads, slot0 in low half
- alloc_ready_o  out  1  at least 2 free entries
- alloc_index_o  out  2*PTR_WIDTH  entry index per slot (tail, tail+1)
- ready_set_i  in  DEPTH  per-entry wakeup from scoreboard
- req_o  out  DEPTH  valid & ready
- req_ls_o  out  DEPTH  valid & is_ls
- head_o  out  PTR_WIDTH  priority point for arbiter
- new_req_o / new_req_ls_o  out  2 each  alloc_valid & rdy_bit / alloc_valid & is_ls, gated by alloc_ready_o
- first_grant_valid_i, second_grant_valid_i  in  1 each  arbiter queue grants
- first_grant_index_i, second_grant_index_i  in  PTR_WIDTH each
- new_grant_i  in  2  arbiter bypass grants (first, second)
- issue_valid_o  out  2  registered issue slots
- issue_data_o  out  2*DATA_WIDTH  registered payloads

## Operation
- State per entry: valid, ready, is_ls, data. Pointers head and tail are PTR_WIDTH+1 bits, with the MSB as the wrap bit.
- span = tail - head (mod 2*DEPTH). alloc_ready_o = (DEPTH - span) >= 2. Full is span == DEPTH. Empty is span == 0.
- Allocation happens when alloc_ready_o is high.
  - A valid slot that is not bypass-granted is written at the next free index in slot order. Slot0 goes to tail. Slot1 goes to tail+1, or to tail if slot0 was bypassed.
  - tail advances by the number of slots written.
  - alloc_index_o reflects this placement.
- Wakeup: ready_set_i[k] sets ready on valid entry k. It is ignored on invalid entries.
- Grant: a queue grant clears valid at index. A bypass grant issues the alloc slot directly and writes no entry.
- Issue ordering candidates are {queue first, queue second, new first, new second}. The first two valid candidates fill issue slot 0 and then slot 1. A grant beyond two is an arbiter error and is asserted, not handled.
- Head update: next head is the first valid entry in circular order from the current head, evaluated after this cycle's frees. If no valid entry exists before tail, next head = next tail.
- Flush has priority over everything else.
  - It clears all valid bits and sets head = tail = 0.
  - issue_valid_o is 0 on the next cycle.
  - Grants and allocations that cycle are dropped.

## Timing
- Reset (async, rstn low): all valid/ready cleared, head = tail = 0, issue_valid_o = 0, issue_data_o = 0.
  - Combinational outputs follow: req_o = req_ls_o = 0, head_o = 0, alloc_ready_o = 1.
- req_o, req_ls_o, new_req*, alloc_ready_o and alloc_index_o are combinational from state and inputs. The arbiter closes its loop in the same cycle.
- Grant in cycle N gives issue_valid_o/issue_data_o in cycle N+1. The entry is freed and head is updated at the N+1 edge. An entry is never granted twice.
- Alloc accepted in cycle N gives entry valid and visible in req_o in N+1.
- ready_set_i in N makes the entry requestable in N+1.
- Simultaneous grant and ready_set on the same entry: the entry is freed.
- Wrap-around: indices are taken modulo DEPTH, and the wrap bit disambiguates full from empty.
- Holes are not reused until head passes them. A queue with span DEPTH and holes still reports alloc_ready_o = 0.

## Test plan
- Reset then allocate 2 ready non-LS ops per cycle for 4 cycles, with no grants returned -> entries 0-7 valid, req_o=0xFF, alloc_ready_o falls to 0 when span=8.
- Queue empty, alloc slot0 ready with new_grant_i=01 -> no entry written, tail stays 0, next cycle issue_valid_o=01 with slot0 payload.
- Entries 0..5 valid, head=0, grant indices 0 and 2 -> next cycle issue_valid_o=11 with data of 0 then 2, head_o=1. A later grant of 1 moves head_o to 3.
- Entries 6,7,0,1 valid with head=6 and tail=10 (wrap), free 6 and 7 -> head_o=0 (wrap bit set), span=2, alloc_ready_o=1, alloc_index_o={3,2}.
- Full queue with ready_set_i=0x10 -> only req_o[4] rises next cycle. A grant on 4 with queue grant plus new_grant_i=01 -> slot0=entry4, slot1=new op.
- Flush asserted in the same cycle as two grants and an allocation -> next cycle issue_valid_o=0, req_o=0, head_o=0, alloc_ready_o=1. Assert rstn low mid-queue -> same values immediately.
